// File: rtl/cpu_mem_pkg.sv
// Shared CPU/memory definitions: fetch FSM states, byte-lane offsets and
// default sizing for the instruction-memory responder.
package cpu_mem_pkg;

  localparam int unsigned DEF_DEPTH   = 1024;
  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_LATENCY = 3;

  // Big-endian lanes: byte offset 0 within a word lands in [31:24].
  localparam int unsigned LANE_B31_24 = 0;
  localparam int unsigned LANE_B23_16 = 1;
  localparam int unsigned LANE_B15_8  = 2;
  localparam int unsigned LANE_B7_0   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } fetch_state_e;

endpackage

// File: rtl/instr_byte_ram.sv
// Byte-organised instruction array: one synchronous byte write port and a
// combinational 32-bit big-endian read of the word at a word index.
module instr_byte_ram
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-3:0] ridx,
  output logic [31:0]       rdata
);

  logic [7:0] mem_q [DEPTH];

  // Byte write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Four byte taps assembled MSB-first; a same-edge write is not yet visible.
  always_comb begin
    rdata = {mem_q[{ridx, 2'(LANE_B31_24)}],
             mem_q[{ridx, 2'(LANE_B23_16)}],
             mem_q[{ridx, 2'(LANE_B15_8)}],
             mem_q[{ridx, 2'(LANE_B7_0)}]};
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: returns the word at the CPU fetch address
// after LATENCY clock edges, stalling the CPU with BUSYWAIT meanwhile.
module instr_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned LATENCY     = DEF_LATENCY,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic [31:0]       ADDRESS,
  output logic [31:0]       INSTRUCTION,
  output logic              BUSYWAIT,
  input  logic              LOAD_EN,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic [7:0]        LOAD_DATA,
  output logic [15:0]       FETCH_CNT
);

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-3:0] widx_q, widx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic [15:0]       fetch_cnt_q, fetch_cnt_d;

  logic [ADDR_W-3:0] req_widx;
  logic [ADDR_W-3:0] ridx;
  logic [31:0]       rdata;
  logic              busy;
  logic              addr_unused;

  assign req_widx    = ADDRESS[ADDR_W-1:2];
  assign addr_unused = ^{ADDRESS[31:ADDR_W], ADDRESS[1:0]};

  instr_byte_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (CLK),
    .we    (LOAD_EN),
    .waddr (LOAD_ADDR),
    .wdata (LOAD_DATA),
    .ridx  (ridx),
    .rdata (rdata)
  );

  // State, latched address, latency counter, result and fetch count.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      widx_q      <= '0;
      cnt_q       <= '0;
      instr_q     <= RESET_INSTR;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Fetch FSM: capture in IDLE, count in BUSY, one-cycle DONE handshake.
  // The RAM is read at the live address in IDLE so LATENCY=1 can complete
  // on the capture edge; otherwise it reads the latched word index.
  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    fetch_cnt_d = fetch_cnt_q;
    ridx        = widx_q;
    busy        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = READ;
        ridx = req_widx;
        if (READ) begin
          widx_d = req_widx;
          cnt_d  = 4'd1;
          if (LATENCY == 1) begin
            instr_d     = rdata;
            fetch_cnt_d = fetch_cnt_q + 16'd1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (!READ) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d       = cnt_q + 4'd1;
          instr_d     = rdata;
          fetch_cnt_d = fetch_cnt_q + 16'd1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign BUSYWAIT    = busy & RESET;
  assign INSTRUCTION = instr_q;
  assign FETCH_CNT   = fetch_cnt_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder with LATENCY=3.
module tb_instr_mem_responder;

  localparam int unsigned LAT = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic [31:0] ADDRESS;
  logic [31:0] INSTRUCTION;
  logic        BUSYWAIT;
  logic        LOAD_EN;
  logic [9:0]  LOAD_ADDR;
  logic [7:0]  LOAD_DATA;
  logic [15:0] FETCH_CNT;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = 16'd0;

  instr_mem_responder #(
    .DEPTH       (1024),
    .ADDR_W      (10),
    .LATENCY     (LAT),
    .RESET_INSTR (32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .READ        (READ),
    .ADDRESS     (ADDRESS),
    .INSTRUCTION (INSTRUCTION),
    .BUSYWAIT    (BUSYWAIT),
    .LOAD_EN     (LOAD_EN),
    .LOAD_ADDR   (LOAD_ADDR),
    .LOAD_DATA   (LOAD_DATA),
    .FETCH_CNT   (FETCH_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
    LOAD_EN   = 1'b1;
    LOAD_ADDR = a;
    LOAD_DATA = d;
    tick();
    LOAD_EN = 1'b0;
  endtask

  // Full fetch from IDLE; ADDRESS is disturbed during BUSY to prove latching.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    READ    = 1'b1;
    ADDRESS = addr;
    #1;
    check({tag, " busy c0"}, 32'(BUSYWAIT), 32'd1);
    for (int unsigned k = 1; k < LAT; k++) begin
      tick();
      ADDRESS = 32'h0000_0020;
      check({tag, " busy"}, 32'(BUSYWAIT), 32'd1);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check({tag, " done busy"}, 32'(BUSYWAIT), 32'd0);
    check({tag, " instr"}, INSTRUCTION, exp);
    check({tag, " cnt"}, 32'(FETCH_CNT), 32'(exp_cnt));
    READ = 1'b0;
    tick();
  endtask

  initial begin
    int          ndone;
    int          done_at [2];
    logic [31:0] done_instr [2];

    RESET     = 1'b0;
    READ      = 1'b1;
    ADDRESS   = '0;
    LOAD_EN   = 1'b0;
    LOAD_ADDR = '0;
    LOAD_DATA = '0;

    // Reset with READ high: stall suppressed, registers at reset values.
    #1;
    check("rst busy", 32'(BUSYWAIT), 32'd0);
    check("rst instr", INSTRUCTION, 32'h0);
    check("rst cnt", 32'(FETCH_CNT), 32'd0);
    tick();
    tick();
    check("rst busy held", 32'(BUSYWAIT), 32'd0);
    RESET = 1'b1;
    #1;
    check("rel busy", 32'(BUSYWAIT), 32'd1);
    READ = 1'b0;
    #1;
    check("idle busy", 32'(BUSYWAIT), 32'd0);
    tick();

    load_byte(10'd0, 8'h01);
    load_byte(10'd1, 8'h02);
    load_byte(10'd2, 8'h03);
    load_byte(10'd3, 8'h04);
    load_byte(10'd4, 8'hA1);
    load_byte(10'd5, 8'hB2);
    load_byte(10'd6, 8'hC3);
    load_byte(10'd7, 8'hD4);

    do_fetch("f0", 32'h0000_0000, 32'h0102_0304);
    do_fetch("f4", 32'h0000_0004, 32'hA1B2_C3D4);
    do_fetch("f406", 32'h0000_0406, 32'hA1B2_C3D4);
    do_fetch("fwrap", 32'hFFFF_F003, 32'h0102_0304);

    // Abort: READ dropped after one cycle in BUSY.
    READ    = 1'b1;
    ADDRESS = 32'h0000_0004;
    tick();
    READ = 1'b0;
    #1;
    check("abort busy in BUSY", 32'(BUSYWAIT), 32'd1);
    tick();
    check("abort busy", 32'(BUSYWAIT), 32'd0);
    tick();
    tick();
    tick();
    check("abort instr", INSTRUCTION, 32'h0102_0304);
    check("abort cnt", 32'(FETCH_CNT), 32'(exp_cnt));
    do_fetch("post abort", 32'h0000_0000, 32'h0102_0304);

    // Back-to-back with READ held: DONE cycles LATENCY+1 apart.
    ndone   = 0;
    READ    = 1'b1;
    ADDRESS = 32'h0000_0000;
    for (int t = 0; t < 16; t++) begin
      #1;
      if (!BUSYWAIT && ndone < 2) begin
        done_at[ndone]    = t;
        done_instr[ndone] = INSTRUCTION;
        ndone++;
        ADDRESS = 32'h0000_0004;
        if (ndone == 2) begin
          READ = 1'b0;
          break;
        end
      end
      tick();
    end
    exp_cnt = exp_cnt + 16'd2;
    check("b2b done count", 32'(ndone), 32'd2);
    if (ndone == 2) begin
      check("b2b first done", 32'(done_at[0]), 32'(LAT));
      check("b2b spacing", 32'(done_at[1] - done_at[0]), 32'(LAT + 1));
      check("b2b instr0", done_instr[0], 32'h0102_0304);
      check("b2b instr1", done_instr[1], 32'hA1B2_C3D4);
    end
    check("b2b cnt", 32'(FETCH_CNT), 32'(exp_cnt));
    READ = 1'b0;
    tick();

    // Collision: byte 1 written on the completion edge of a fetch of 0.
    READ    = 1'b1;
    ADDRESS = 32'h0000_0000;
    for (int unsigned k = 1; k < LAT; k++) tick();
    LOAD_EN   = 1'b1;
    LOAD_ADDR = 10'd1;
    LOAD_DATA = 8'hFF;
    tick();
    LOAD_EN = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    check("coll busy", 32'(BUSYWAIT), 32'd0);
    check("coll instr", INSTRUCTION, 32'h0102_0304);
    check("coll cnt", 32'(FETCH_CNT), 32'(exp_cnt));
    READ = 1'b0;
    tick();
    do_fetch("coll refetch", 32'h0000_0000, 32'h01FF_0304);

    // Reset mid-fetch aborts and clears.
    READ    = 1'b1;
    ADDRESS = 32'h0000_0004;
    tick();
    RESET = 1'b0;
    #1;
    check("midrst busy", 32'(BUSYWAIT), 32'd0);
    check("midrst instr", INSTRUCTION, 32'h0);
    check("midrst cnt", 32'(FETCH_CNT), 32'd0);
    READ = 1'b0;
    tick();
    RESET   = 1'b1;
    exp_cnt = 16'd0;
    tick();
    check("midrst idle instr", INSTRUCTION, 32'h0);
    do_fetch("after rst", 32'h0000_0004, 32'hA1B2_C3D4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Synthesizable instruction-memory responder: the memory end of the CPU fetch interface (CPU drives PC and a read strobe; this block returns the 32-bit INSTRUCTION).
- Replaces the ideal zero-wait bench memory. It adds a multi-cycle access latency and a BUSYWAIT stall signal, so CPU stall logic can be exercised.
- Byte-organised, big-endian word assembly. A byte-wide load port fills the array before or during execution.

Parameters:
- DEPTH, 1024: memory size in bytes; must be a power of two and a multiple of 4.
- ADDR_W, 10: log2(DEPTH); number of address bits used for indexing.
- LATENCY, 3: number of posedges from READ capture to INSTRUCTION update; legal range 1..15.
- RESET_INSTR, 32'h0000_0000: value driven on INSTRUCTION after reset.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
- READ  input  1  fetch request from the CPU; held high until BUSYWAIT falls.
- ADDRESS  input  32  fetch byte address (CPU PC).
- INSTRUCTION  output  32  fetched word, registered.
- BUSYWAIT  output  1  stall to the CPU; high while a fetch is outstanding.
- LOAD_EN  input  1  byte write enable for the load port.
- LOAD_ADDR  input  ADDR_W  byte address for the load port.
- LOAD_DATA  input  8  byte to write.
- FETCH_CNT  output  16  count of completed fetches, registered.

Behaviour:
- Reset (RESET=0, async):
  - state=IDLE, INSTRUCTION=RESET_INSTR, FETCH_CNT=0, latency counter=0.
  - BUSYWAIT forced 0 while RESET=0.
  - Array contents are not reset.
  - Reset mid-fetch aborts the fetch; no INSTRUCTION update.
- Addressing:
  - ADDRESS[1:0] ignored (word aligned).
  - Index = {ADDRESS[ADDR_W-1:2],2'b00}; upper ADDRESS bits ignored, so addresses wrap modulo DEPTH.
- Word assembly: INSTRUCTION = {mem[a+0], mem[a+1], mem[a+2], mem[a+3]}; mem[a+0] lands in [31:24].
- States: IDLE, BUSY, DONE.
- IDLE:
  - BUSYWAIT = READ (combinational, so the CPU stalls in the request cycle).
  - Posedge with READ=1: latch the word address and set cnt=1.
  - If LATENCY=1: load INSTRUCTION in the same edge, go DONE. Otherwise go BUSY.
- BUSY:
  - BUSYWAIT=1; cnt increments each posedge.
  - On the posedge where cnt reaches LATENCY-1 → LATENCY: INSTRUCTION <= word at the latched address, FETCH_CNT += 1, go DONE.
  - READ=0 sampled in BUSY: abort, go IDLE; INSTRUCTION and FETCH_CNT unchanged.
  - ADDRESS changes during BUSY are ignored; the latched address is used.
- DONE:
  - BUSYWAIT=0 for exactly one cycle; INSTRUCTION held.
  - Next posedge → IDLE unconditionally; READ is not re-sampled in DONE.
  - A back-to-back fetch is therefore captured no earlier than the cycle after DONE.
- Timing summary: READ rises in cycle 0 → BUSYWAIT high in cycles 0..LATENCY-1 → INSTRUCTION valid and BUSYWAIT low in cycle LATENCY.
- Load port:
  - Byte write at posedge when LOAD_EN=1, accepted in any state.
  - Same-edge collision with the INSTRUCTION load edge on a byte of the fetched word: the old byte is returned (read-before-write). The new byte is visible to later fetches.
- FETCH_CNT wraps from 16'hFFFF to 0.
- INSTRUCTION changes only on completion edges or reset.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - byte-lane constants (MSB lane = offset 0);
  - default LATENCY and DEPTH constants, shared with the CPU and benches.
- Sub-module instr_byte_ram:
  - DEPTH x 8 array;
  - one synchronous byte write port;
  - four combinational byte read taps at a word-aligned index, where the whole 32-bit word is assembled.
- The responder FSM, latency counter and fetch counter stay in instr_mem_responder.

Test Plan:
- Reset: RESET=0 with READ=1 → BUSYWAIT=0, INSTRUCTION=0, FETCH_CNT=0. Release RESET → BUSYWAIT=1 immediately (READ still high).
- Basic fetch, LATENCY=3:
  - Setup: load bytes 0..3 = 8'h01,8'h02,8'h03,8'h04; READ=1, ADDRESS=0 in cycle 0.
  - Required: BUSYWAIT=1 in cycles 0-2; cycle 3 INSTRUCTION=32'h01020304, BUSYWAIT=0; FETCH_CNT=1.
- Alignment/wrap: ADDRESS=32'h0000_0406 → same word as address 4 (index 4); result equals a fetch of ADDRESS=4.
- Abort: READ high 1 cycle then low in BUSY → state returns to IDLE; INSTRUCTION unchanged; FETCH_CNT unchanged.
- Back-to-back:
  - Stimulus: ADDRESS 0 then 4, READ held high.
  - Required: second capture occurs the cycle after DONE; the two DONE cycles are LATENCY+1 cycles apart; FETCH_CNT=2.
- Load collision: LOAD_EN writing 8'hFF to byte 1 on the completion edge of a fetch at address 0 → INSTRUCTION=32'h01020304. The next fetch of address 0 returns 32'h01FF0304.
